// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encodings, data width and default bit timing.
// The default bit timing constant is also used by the transmitter.
package uart_defs;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a falling-edge detector.
// Flops preset to 1 so an idle-high line produces no edge when leaving reset.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_reg <= '1;
         prev_reg <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign dout = sync_reg[SYNC_STAGES-1];
   assign fall = prev_reg & ~dout;

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a level valid/ack handshake and sticky overrun/framing flags.
// Optional even-parity checking (adds port arx_parity_err) when UART_RX_PARITY_EN is defined.
module uart_rx_port
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic [7:0] arx_data,
   output logic       arx_valid,
   input  logic       arx_ack,
   output logic       arx_busy,
   output logic       arx_overrun,
   output logic       arx_frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       arx_parity_err
`endif
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

   logic              rxs;
   logic              rx_fall;
   rx_state_t         state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg;
   logic [2:0]        bit_reg;
   logic [7:0]        shift_reg;
   logic              baud_wrap;
   logic              sample_data;
   logic              commit;
   logic              stop_bad;
`ifdef UART_RX_PARITY_EN
   logic              parity_bad_reg;
   logic              parity_fail;
`endif

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (rxd),
      .dout    (rxs),
      .fall    (rx_fall)
   );

   assign baud_wrap = (baud_reg == BAUD_LAST);
   assign arx_busy  = (state_reg != ST_IDLE);

   always_comb begin
      state_next  = state_reg;
      sample_data = 1'b0;
      commit      = 1'b0;
      stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_fail = 1'b0;
`endif
      case (state_reg)
         ST_IDLE:  if (rx_fall) state_next = ST_START;
         ST_START: if (baud_reg == HALF_LAST) state_next = rxs ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (baud_wrap) begin
               sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_reg == BIT_LAST) state_next = ST_PARITY;
`else
               if (bit_reg == BIT_LAST) state_next = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (baud_wrap) begin
               state_next  = ST_STOP;
               parity_fail = (rxs != ^shift_reg);
            end
         end
`endif
         ST_STOP: begin
            if (baud_wrap) begin
               state_next = ST_IDLE;
               stop_bad   = ~rxs;
`ifdef UART_RX_PARITY_EN
               commit     = rxs & ~parity_bad_reg;
`else
               commit     = rxs;
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Receive datapath: baud counter restarts on every state change.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next != state_reg || state_reg == ST_IDLE || baud_wrap)
            baud_reg <= '0;
         else
            baud_reg <= baud_reg + 1'b1;
         if (state_reg != ST_DATA) begin
            bit_reg <= '0;
         end else if (sample_data) begin
            shift_reg[bit_reg] <= rxs;
            bit_reg            <= bit_reg + 1'b1;
         end
      end
   end

   // CPU side: an ack cycle clears the flags but still records any event landing in that cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         arx_data      <= 8'h00;
         arx_valid     <= 1'b0;
         arx_overrun   <= 1'b0;
         arx_frame_err <= 1'b0;
      end else if (arx_ack) begin
         arx_valid     <= 1'b0;
         arx_overrun   <= commit;
         arx_frame_err <= stop_bad;
      end else begin
         if (commit) begin
            if (arx_valid) begin
               arx_overrun <= 1'b1;
            end else begin
               arx_data  <= shift_reg;
               arx_valid <= 1'b1;
            end
         end
         if (stop_bad) arx_frame_err <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         parity_bad_reg <= 1'b0;
         arx_parity_err <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE)
            parity_bad_reg <= 1'b0;
         else if (parity_fail)
            parity_bad_reg <= 1'b1;
         if (arx_ack)
            arx_parity_err <= parity_fail;
         else if (parity_fail)
            arx_parity_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 16 clocks per bit.
// Define UART_RX_PARITY_EN to also exercise the even-parity build.
module tb_uart_rx_port;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_EXTRA = CPB;
`else
   localparam int PAR_EXTRA = 0;
`endif
   // 9.5 bit periods (152 +/- 1) from the synchronised edge, plus up to 3 clocks of input sync/edge delay.
   localparam int LAT_MIN = 151 + PAR_EXTRA;
   localparam int LAT_MAX = 156 + PAR_EXTRA;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] arx_data;
   logic       arx_valid;
   logic       arx_ack = 1'b0;
   logic       arx_busy;
   logic       arx_overrun;
   logic       arx_frame_err;
`ifdef UART_RX_PARITY_EN
   logic       arx_parity_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_port #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rxd           (rxd),
      .arx_data      (arx_data),
      .arx_valid     (arx_valid),
      .arx_ack       (arx_ack),
      .arx_busy      (arx_busy),
      .arx_overrun   (arx_overrun),
`ifdef UART_RX_PARITY_EN
      .arx_frame_err (arx_frame_err),
      .arx_parity_err(arx_parity_err)
`else
      .arx_frame_err (arx_frame_err)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      start_cyc = cyc;
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ par_flip;
      tick(CPB);
`else
      if (par_flip) $display("note: parity bit requested but parity is disabled");
`endif
      rxd = stop_bit;
      tick(CPB);
   endtask

   task automatic wait_valid(input string tag, input int limit, output int lat);
      lat = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (arx_valid) begin
            lat = cyc - start_cyc;
            break;
         end
      end
      if (lat < 0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      else $display("rx %s: byte %02h valid %0d clocks after start", tag, arx_data, lat);
   endtask

   task automatic pulse_ack();
      arx_ack = 1'b1;
      tick(1);
      arx_ack = 1'b0;
      tick(1);
   endtask

   initial begin
      logic [7:0] exp_b [2];
      int lat;
      int busy_cnt;
      exp_b[0] = 8'h55;
      exp_b[1] = 8'hA3;

      // Reset state
      tick(3);
      check_eq("rst_data", {24'd0, arx_data}, 32'h00);
      check_eq("rst_valid", {31'd0, arx_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, arx_busy}, 32'd0);
      reset_n = 1'b1;
      tick(3);

      // Back-to-back 0x55, 0xA3 with ack after each
      fork
         begin
            send_frame(8'h55, 1'b1, 1'b0);
            send_frame(8'hA3, 1'b1, 1'b0);
         end
         begin
            for (int k = 0; k < 2; k++) begin
               wait_valid("b2b", 400, lat);
               check_eq("b2b_lat_in_window", {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 32'd1);
               check_eq("b2b_data", {24'd0, arx_data}, {24'd0, exp_b[k]});
               check_eq("b2b_overrun", {31'd0, arx_overrun}, 32'd0);
               check_eq("b2b_frame_err", {31'd0, arx_frame_err}, 32'd0);
               arx_ack = 1'b1;
               @(posedge clk);
               #1 arx_ack = 1'b0;
               @(negedge clk);
               check_eq("b2b_ack_clears_valid", {31'd0, arx_valid}, 32'd0);
            end
         end
      join
      tick(4);

      // 4-clock glitch: false start
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (arx_busy) busy_cnt++;
      end
      $display("glitch: busy for %0d clocks", busy_cnt);
      check_eq("glitch_busy_1_to_9", {31'd0, (busy_cnt >= 1 && busy_cnt <= 9)}, 32'd1);
      check_eq("glitch_idle", {31'd0, arx_busy}, 32'd0);
      check_eq("glitch_valid", {31'd0, arx_valid}, 32'd0);
      check_eq("glitch_frame_err", {31'd0, arx_frame_err}, 32'd0);
      tick(1);

      // 0x3C with stop bit low
      send_frame(8'h3C, 1'b0, 1'b0);
      rxd = 1'b1;
      tick(2);
      $display("frame 3C with low stop: frame_err=%0d valid=%0d", arx_frame_err, arx_valid);
      check_eq("ferr_set", {31'd0, arx_frame_err}, 32'd1);
      check_eq("ferr_valid", {31'd0, arx_valid}, 32'd0);
      pulse_ack();
      check_eq("ferr_cleared", {31'd0, arx_frame_err}, 32'd0);

      // 0x11 then 0x22 without ack: overrun, first byte kept
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      tick(2);
      $display("overrun: data=%02h valid=%0d overrun=%0d", arx_data, arx_valid, arx_overrun);
      check_eq("ovr_data", {24'd0, arx_data}, 32'h11);
      check_eq("ovr_flag", {31'd0, arx_overrun}, 32'd1);
      check_eq("ovr_valid", {31'd0, arx_valid}, 32'd1);
      arx_ack = 1'b1;
      tick(2);
      arx_ack = 1'b0;
      tick(2);
      check_eq("ovr_valid_cleared", {31'd0, arx_valid}, 32'd0);
      check_eq("ovr_flag_cleared", {31'd0, arx_overrun}, 32'd0);
      send_frame(8'h33, 1'b1, 1'b0);
      wait_valid("after_ovr", 100, lat);
      check_eq("ovr_next_data", {24'd0, arx_data}, 32'h33);
      tick(2);

      // Reset during bit 4 of 0xFF (0x33 still unread), then 0x81
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            tick(CPB * 5 + 8);
            reset_n = 1'b0;
            tick(1);
            check_eq("midrst_data", {24'd0, arx_data}, 32'h00);
            check_eq("midrst_valid", {31'd0, arx_valid}, 32'd0);
            check_eq("midrst_busy", {31'd0, arx_busy}, 32'd0);
            check_eq("midrst_overrun", {31'd0, arx_overrun}, 32'd0);
            check_eq("midrst_frame_err", {31'd0, arx_frame_err}, 32'd0);
            tick(2);
            reset_n = 1'b1;
         end
      join
      tick(4);
      check_eq("midrst_no_partial", {31'd0, arx_valid}, 32'd0);
      send_frame(8'h81, 1'b1, 1'b0);
      wait_valid("after_rst", 100, lat);
      check_eq("midrst_next_data", {24'd0, arx_data}, 32'h81);
      pulse_ack();

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit is 1
      send_frame(8'h07, 1'b1, 1'b1);
      tick(2);
      $display("parity bad 07: parity_err=%0d valid=%0d", arx_parity_err, arx_valid);
      check_eq("par_err_set", {31'd0, arx_parity_err}, 32'd1);
      check_eq("par_err_valid", {31'd0, arx_valid}, 32'd0);
      pulse_ack();
      check_eq("par_err_cleared", {31'd0, arx_parity_err}, 32'd0);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_valid("par_ok", 100, lat);
      check_eq("par_ok_data", {24'd0, arx_data}, 32'h07);
      check_eq("par_ok_err", {31'd0, arx_parity_err}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Serial UART receiver: the receive-side counterpart of the CPU's existing `atx_*` transmit port.
- Deserialises 8N1 frames from the `rxd` pin into a byte register that the CPU reads as `arx_data`.
- Uses a level handshake (`arx_valid` / `arx_ack`) slow enough for firmware polling loops.
- Sits beside the transmitter on the DE0_nano top level, clocked by the system clock.

Parameters:
- `CLKS_PER_BIT`, 434, system clocks per bit period (50 MHz / 115200); must be >= 8.
- `SYNC_STAGES`, 2, flops in the `rxd` metastability synchroniser; legal range 2..3.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous reset, active low.
- `rxd`  in  1  asynchronous serial input; idle high.
- `arx_data`  out  8  last received byte; LSB is the first bit on the wire.
- `arx_valid`  out  1  `arx_data` holds an unread byte.
- `arx_ack`  in  1  CPU level acknowledge; high = byte consumed.
- `arx_busy`  out  1  a frame is in progress (state != IDLE).
- `arx_overrun`  out  1  sticky: a byte completed while `arx_valid` was high.
- `arx_frame_err`  out  1  sticky: stop bit sampled low.

Behaviour:
- Reset (`reset_n` low at a `clk` edge):
  - State = IDLE; bit counter and baud counter = 0.
  - `arx_data` = 0x00; `arx_valid`, `arx_busy`, `arx_overrun`, `arx_frame_err` = 0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame; no partial byte is ever presented.
- Synchroniser: `rxd` passes through `SYNC_STAGES` flops to give `rxs`. A falling-edge detector compares `rxs` with its previous value.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps. It reloads to 0 on every state entry.
- State machine:
  - IDLE: on a falling edge of `rxs` -> START.
  - START: wait `CLKS_PER_BIT`/2 clocks (integer divide), then sample `rxs`.
    - Sample 1 -> false start: return to IDLE with no flags changed.
    - Sample 0 -> DATA with bit index 0 and the baud counter cleared.
  - DATA: at each baud wrap, sample `rxs` into `shift[bit_index]` and increment the index. After index 7 is sampled -> STOP (or PARITY when the optional feature is enabled).
  - STOP: at the baud wrap, sample `rxs`.
    - Sample 1 -> commit.
    - Sample 0 -> set `arx_frame_err`, discard the byte, go to IDLE.
    - The next start bit is accepted from the cycle after the stop sample. No full stop period is waited, so back-to-back frames are supported.
- Commit (one cycle):
  - If `arx_valid` = 0 and `arx_ack` = 0: `arx_data` <= shift; `arx_valid` <= 1.
  - If `arx_valid` = 1: set `arx_overrun`; the old `arx_data` is retained and the new byte is dropped.
  - If `arx_valid` = 0 but `arx_ack` is still high (CPU has not lowered ack): treat as overrun, with the same drop rule.
- Handshake:
  - `arx_ack` high for any cycle clears `arx_valid`, `arx_overrun` and `arx_frame_err` on the next edge.
  - A new byte is presented only once `arx_ack` has returned low.
  - Commit and ack in the same cycle: ack wins. The flags clear and the committed byte is treated as overrun, so `arx_overrun` = 1 on the following cycle.
- `arx_busy` is combinational from state (state != IDLE).
- Latency: `arx_valid` rises 1 clock after the stop-bit sample point, i.e. about 9.5 bit periods after the start falling edge.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at a baud wrap.
  - Mismatch sets the extra output `arx_parity_err` (sticky, reset 0, cleared by `arx_ack`) and discards the byte. The stop bit is still checked.
- Undefined: pure 8N1; the port `arx_parity_err` does not exist.

Decomposition:
- Shared package/include `uart_defs`:
  - State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit.
  - `UART_DATA_BITS` = 8.
  - Default `CLKS_PER_BIT` constant, also used by the transmitter.
- Sub-module `uart_rx_sync`: parameterised synchroniser plus falling-edge detector, reusable for other asynchronous inputs.

Test Plan (bench uses `CLKS_PER_BIT` = 16):
- Send 0x55, then 0xA3 back-to-back; pulse `arx_ack` after each.
  - Expect `arx_data` = 0x55 then 0xA3, with `arx_valid` rising 152±1 clocks after each start edge.
  - Expect both flags 0.
- Glitch `rxd` low for 4 clocks.
  - Expect return to IDLE, `arx_valid` = 0, `arx_busy` high for no more than 9 clocks.
- Send 0x3C with the stop bit driven low.
  - Expect `arx_frame_err` = 1, `arx_valid` = 0; one `arx_ack` cycle clears the flag.
- Send 0x11 and 0x22 without ack.
  - Expect `arx_data` = 0x11, `arx_overrun` = 1.
  - After ack high then low, send 0x33: expect `arx_data` = 0x33.
- Assert `reset_n` low mid-frame at bit 4 of 0xFF, release, send 0x81.
  - Expect all outputs 0 during reset, then `arx_data` = 0x81.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0.
  - Expect `arx_parity_err` = 1 and the byte discarded.
  - Send 0x07 with parity bit 1: expect `arx_data` = 0x07.
